// File: rtl/uart_instruction_link.sv
// uart_instruction_link
//   UART front end of the narvie debug link (8N1, LSB first).
//   The receiver assembles four valid serial bytes into a 32-bit instruction
//   word, first byte in the most significant position. The transmitter sends
//   one byte per accepted request and is used to stream the register file
//   back to the host. Receiver and transmitter run independently (full duplex).
//
// Parameters
//   BAUDRATE         clock cycles per bit (>= 4); 104 -> 115200 baud at 12 MHz
//
// Ports
//   clk12            system clock, rising edge
//   rstn             synchronous active-low reset
//   rx               asynchronous serial input, idle high
//   instruction      last complete received word
//   instruction_rcv  one-cycle pulse when instruction updates
//   tx_data          byte to send, sampled only on acceptance
//   tx_start         request to send tx_data
//   tx               serial output, idle high
//   tx_ready         transmitter idle and able to accept a request
module uart_instruction_link #(
  parameter int BAUDRATE = 104
) (
  input  logic        clk12,
  input  logic        rstn,
  input  logic        rx,
  output logic [31:0] instruction,
  output logic        instruction_rcv,
  input  logic [7:0]  tx_data,
  input  logic        tx_start,
  output logic        tx,
  output logic        tx_ready
);

  localparam int CW = $clog2(BAUDRATE);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUDRATE - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUDRATE / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // Receiver state
  logic          rx_meta_q, rx_meta_d;
  logic          rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  rx_state_t     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [31:0]   asm_word_q, asm_word_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [31:0]   instr_q, instr_d;
  logic          instr_rcv_q, instr_rcv_d;

  // Transmitter state
  tx_state_t     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;
  logic          tx_rdy_q, tx_rdy_d;

  assign instruction     = instr_q;
  assign instruction_rcv = instr_rcv_q;
  assign tx              = tx_line_q;
  assign tx_ready        = tx_rdy_q;

  // Receiver next state. A start is only recognised on a true falling edge
  // of the synchronized line (rx_prev_q high, rx_sync_q low). The edge flops
  // reset low, so a line that is already low when reset releases, or a stop
  // bit held low after a framing error, never launches a bogus frame.
  always_comb begin
    rx_meta_d   = rx;
    rx_sync_d   = rx_meta_q;
    rx_prev_d   = rx_sync_q;
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_bit_d    = rx_bit_q;
    rx_shift_d  = rx_shift_q;
    asm_word_d  = asm_word_q;
    byte_cnt_d  = byte_cnt_q;
    instr_d     = instr_q;
    instr_rcv_d = 1'b0;

    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        // Re-check the line at mid start bit; a high line means a glitch.
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        // A low stop bit drops the byte without touching the byte count.
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            asm_word_d = {asm_word_q[23:0], rx_shift_q};
            byte_cnt_d = byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              instr_d     = {asm_word_q[23:0], rx_shift_q};
              instr_rcv_d = 1'b1;
            end
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Transmitter next state. tx_ready drops on the acceptance edge so the
  // control logic always sees a low cycle; it rises again after the full
  // stop bit, which lets a held tx_start start the next frame right away.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_rdy_d   = tx_rdy_q;

    case (tx_state_q)
      TX_IDLE: begin
        if (tx_start && tx_rdy_q) begin
          tx_shift_d = tx_data;
          tx_line_d  = 1'b0;
          tx_rdy_d   = 1'b0;
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = 3'd0;
          tx_line_d  = tx_shift_q[0];
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_line_d  = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_rdy_d   = 1'b1;
          tx_state_d = TX_IDLE;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // All state registers, synchronous active-low reset.
  always_ff @(posedge clk12) begin
    if (!rstn) begin
      rx_meta_q   <= 1'b0;
      rx_sync_q   <= 1'b0;
      rx_prev_q   <= 1'b0;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= '0;
      rx_bit_q    <= 3'd0;
      rx_shift_q  <= 8'h00;
      asm_word_q  <= 32'h0;
      byte_cnt_q  <= 2'd0;
      instr_q     <= 32'h0;
      instr_rcv_q <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= '0;
      tx_bit_q    <= 3'd0;
      tx_shift_q  <= 8'h00;
      tx_line_q   <= 1'b1;
      tx_rdy_q    <= 1'b1;
    end else begin
      rx_meta_q   <= rx_meta_d;
      rx_sync_q   <= rx_sync_d;
      rx_prev_q   <= rx_prev_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_bit_q    <= rx_bit_d;
      rx_shift_q  <= rx_shift_d;
      asm_word_q  <= asm_word_d;
      byte_cnt_q  <= byte_cnt_d;
      instr_q     <= instr_d;
      instr_rcv_q <= instr_rcv_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
      tx_line_q   <= tx_line_d;
      tx_rdy_q    <= tx_rdy_d;
    end
  end

endmodule

// File: tb/tb_uart_instruction_link.sv
// Testbench for uart_instruction_link at BAUDRATE = 104.
// Expected instruction words are queued before the byte that completes them
// and popped by a monitor on every instruction_rcv pulse; transmitter frames
// are compared bit by bit at mid-bit against the 8N1 frame built here.
module tb_uart_instruction_link;

  localparam int BAUD = 104;

  logic        clk12 = 1'b0;
  logic        rstn = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_start = 1'b0;
  logic [31:0] instruction;
  logic        instruction_rcv;
  logic        tx;
  logic        tx_ready;

  int          checks = 0;
  int          failures = 0;
  int          pulseCount = 0;
  logic [31:0] expQ[$];

  uart_instruction_link #(.BAUDRATE(BAUD)) dut (
    .clk12          (clk12),
    .rstn           (rstn),
    .rx             (rx),
    .instruction    (instruction),
    .instruction_rcv(instruction_rcv),
    .tx_data        (tx_data),
    .tx_start       (tx_start),
    .tx             (tx),
    .tx_ready       (tx_ready)
  );

  // 12 MHz-style free-running clock (period is arbitrary for the bench)
  always #5 clk12 = ~clk12;

  // Single comparison point: counts every check and every failure
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Every instruction_rcv pulse must match a queued word; a pulse with
  // nothing queued (early or doubled pulse) is a failure
  always @(negedge clk12) begin
    if (instruction_rcv === 1'b1) begin
      pulseCount++;
      checkOutput("rcv_expected", {31'd0, expQ.size() != 0}, 32'd1);
      if (expQ.size() != 0) checkOutput("instruction", instruction, expQ.pop_front());
    end
  end

  // Drive one 8N1 byte on rx followed by one idle bit; called at a negedge
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
    rx = 1'b0;
    repeat (BAUD) @(negedge clk12);
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BAUD) @(negedge clk12);
    end
    rx = stopBit;
    repeat (BAUD) @(negedge clk12);
    rx = 1'b1;
    repeat (BAUD) @(negedge clk12);
  endtask

  // Send a full word MSB byte first and confirm exactly that word arrived
  task automatic sendWord(input logic [31:0] word);
    applyStimulus(word[31:24], 1'b1);
    applyStimulus(word[23:16], 1'b1);
    applyStimulus(word[15:8], 1'b1);
    expQ.push_back(word);
    applyStimulus(word[7:0], 1'b1);
    checkOutput("rcv_drained", 32'(expQ.size()), 32'd0);
    checkOutput("instr_hold", instruction, word);
  endtask

  // Called right after the acceptance edge E0. Checks every bit of the frame
  // at mid-bit and the tx_ready timing; optionally keeps tx_start high for a
  // back-to-back frame or pulses tx_start during data bit 3 (frame index 4)
  task automatic checkTxFrame(input logic [7:0] data, input logic holdStart,
                              input logic [7:0] nextData, input logic midPulse);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    @(negedge clk12);
    tx_start = holdStart;
    tx_data  = nextData;
    checkOutput("tx_ready_drop", {31'd0, tx_ready}, 32'd0);
    checkOutput("tx_start_bit_early", {31'd0, tx}, 32'd0);
    repeat (BAUD / 2) @(negedge clk12);
    for (int i = 0; i < 10; i++) begin
      checkOutput($sformatf("tx_bit%0d", i), {31'd0, tx}, {31'd0, frame[i]});
      if (i < 9) begin
        if (midPulse && i == 4) begin
          tx_start = 1'b1;
          @(negedge clk12);
          tx_start = 1'b0;
          repeat (BAUD - 1) @(negedge clk12);
        end else begin
          repeat (BAUD) @(negedge clk12);
        end
      end
    end
    repeat (BAUD / 2 - 1) @(negedge clk12);
    checkOutput("tx_ready_late", {31'd0, tx_ready}, 32'd0);
    @(negedge clk12);
    checkOutput("tx_ready_back", {31'd0, tx_ready}, 32'd1);
    checkOutput("tx_stop_hold", {31'd0, tx}, 32'd1);
  endtask

  initial begin
    // Reset held three cycles
    rstn = 1'b0;
    repeat (3) @(negedge clk12);
    rstn = 1'b1;
    checkOutput("rst_tx", {31'd0, tx}, 32'd1);
    checkOutput("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("rst_instruction", instruction, 32'h0);
    checkOutput("rst_rcv", {31'd0, instruction_rcv}, 32'd0);
    repeat (5) @(negedge clk12);

    // Two clean words
    sendWord(32'h13000000);
    sendWord(32'hDEADBEEF);

    // Framing error on byte 2, a short glitch, then the word completes on 0x44
    applyStimulus(8'h5A, 1'b1);
    applyStimulus(8'h77, 1'b0);
    rx = 1'b0;
    repeat (20) @(negedge clk12);
    rx = 1'b1;
    repeat (2 * BAUD) @(negedge clk12);
    applyStimulus(8'h3C, 1'b1);
    applyStimulus(8'h96, 1'b1);
    checkOutput("framing_no_early_word", instruction, 32'hDEADBEEF);
    expQ.push_back(32'h5A3C9644);
    applyStimulus(8'h44, 1'b1);
    checkOutput("framing_drained", 32'(expQ.size()), 32'd0);
    checkOutput("framing_word", instruction, 32'h5A3C9644);

    // Single frame 0xA5 with a tx_start pulse while busy
    tx_data  = 8'hA5;
    tx_start = 1'b1;
    @(posedge clk12);
    checkTxFrame(8'hA5, 1'b0, 8'h5A, 1'b1);
    repeat (5) @(negedge clk12);
    checkOutput("tx_idle_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("tx_idle_line", {31'd0, tx}, 32'd1);

    // Back-to-back frames 0x01 then 0x80 with tx_start held high
    tx_data  = 8'h01;
    tx_start = 1'b1;
    @(posedge clk12);
    checkTxFrame(8'h01, 1'b1, 8'h80, 1'b0);
    @(posedge clk12);
    checkTxFrame(8'h80, 1'b0, 8'h00, 1'b0);

    // Reset after two RX bytes and during TX data bit 4
    applyStimulus(8'h12, 1'b1);
    applyStimulus(8'h34, 1'b1);
    tx_data  = 8'hC3;
    tx_start = 1'b1;
    @(posedge clk12);
    @(negedge clk12);
    tx_start = 1'b0;
    repeat (5 * BAUD + BAUD / 2) @(negedge clk12);
    rstn = 1'b0;
    @(negedge clk12);
    rstn = 1'b1;
    checkOutput("midrst_tx", {31'd0, tx}, 32'd1);
    checkOutput("midrst_tx_ready", {31'd0, tx_ready}, 32'd1);
    checkOutput("midrst_instruction", instruction, 32'h0);
    checkOutput("midrst_rcv", {31'd0, instruction_rcv}, 32'd0);
    repeat (BAUD) @(negedge clk12);
    checkOutput("midrst_tx_quiet", {31'd0, tx}, 32'd1);
    sendWord(32'hCAFEF00D);

    checkOutput("pulse_count", 32'(pulseCount), 32'd4);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
